tensor_accumulate: RTL and testbench
====================================

Name: tensor_accumulate

Overview:
- Downstream stage of the 2x2-bit tensor multiply unit in the Mini SPU.
- Consumes one product pair per accepted beat: Tensor_high and Tensor_low, each 4 bits, max value 9.
- Accumulates each lane separately over a programmed vector length, then presents both lane sums plus their combined dot total under a valid/ready handshake.
- Turns the combinational multiplier into a small vector dot-product engine.

Parameters:
- ACC_W, 8, width of each lane accumulator in bits. Minimum 4.
- LEN_W, 4, width of the length field. A vector holds len+1 elements, so 1..2^LEN_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new vector; sampled only in IDLE.
- len  input  LEN_W  element count minus one; latched on accepted start.
- abort  input  1  synchronous cancel; returns to IDLE from any state.
- in_valid  input  1  product pair present.
- in_ready  output  1  block accepts a product pair this cycle.
- prod_high  input  4  upper-lane product (Tensor_high).
- prod_low  input  4  lower-lane product (Tensor_low).
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- acc_high  output  ACC_W  upper-lane sum.
- acc_low  output  ACC_W  lower-lane sum.
- dot  output  ACC_W+1  acc_high + acc_low.
- sat  output  1  sticky flag: a lane saturated during this vector.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state = IDLE; in_ready = 0; out_valid = 0; busy = 0.
  - acc_high = acc_low = 0; dot = 0; sat = 0.
  - element counter = 0; latched length = 0.
- Reset asserted mid-operation discards everything immediately.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready = 0; out_valid = 0.
  - start = 1 for one cycle does all of the following on that edge: latch len; clear both accumulators, the counter and sat; move to ACCUM.
  - acc_high, acc_low and dot keep the previous result until start.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready.
  - On each beat: acc_high += zero-extended prod_high; acc_low += zero-extended prod_low; counter increments.
  - If the beat is accepted while counter == latched len, this is the last element. State moves to DONE on that edge with the final sums registered.
  - Cycles with in_valid = 0 are stalls: no state change.
- DONE:
  - out_valid = 1; in_ready = 0.
  - acc_high, acc_low, dot and sat hold stable while out_ready = 0.
  - out_valid & out_ready moves the state to IDLE on that edge.
  - Outputs keep their values in IDLE until the next start.
- Latency: result is valid the cycle after the last beat is accepted. A vector of N elements streamed back-to-back gives out_valid N cycles after the first accepted beat.
- Saturation:
  - Each lane saturates at 2^ACC_W - 1 and never wraps.
  - Any clamped addition sets sat; sat stays set until the next accepted start.
  - dot = acc_high + acc_low at full ACC_W+1 width, never saturated.
  - With defaults the worst case is 16 * 9 = 144, so no saturation occurs.
- abort:
  - In ACCUM or DONE, moves to IDLE next edge and drops in_ready/out_valid.
  - Accumulators keep their partial values; sat is unchanged.
  - abort has priority over in_valid, out_ready and start in the same cycle.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins and the state stays IDLE.
- len = 0 gives a single-element vector. len = all-ones gives 2^LEN_W elements, and the counter must not wrap before the compare.
- prod_* values above 9 are not generated by the multiplier but are summed as-is.

Test Plan:
- Reset check: assert rst_n low mid-ACCUM after 3 beats -> all outputs 0, state IDLE, in_ready 0, without waiting for a clock edge.
- Basic vector: start, len = 3; beats (high, low) = (9,4), (1,2), (0,3), (6,6) back-to-back -> out_valid on the cycle after the 4th beat; acc_high = 16, acc_low = 15, dot = 31, sat = 0.
- Stall and backpressure: len = 1; in_valid toggled 1,0,0,1 with (3,3) then (2,1); out_ready held 0 for 5 cycles ->
  - exactly 2 beats accepted;
  - acc_high = 5, acc_low = 4, dot = 9, stable the whole time;
  - IDLE on the cycle after out_ready rises.
- Boundaries: len = 0 with one beat (9,9) -> 9 / 9 / 18. Then len = 15 with sixteen (9,9) beats -> 144 / 144 / 288, sat = 0.
- Saturation (ACC_W = 6): len = 15, sixteen (9,1) beats -> acc_high = 63, acc_low = 16, dot = 79, sat = 1. Next start clears sat.
- Abort and ignored start: abort after 2 beats -> IDLE next cycle, in_ready 0, no out_valid. A start pulse during DONE is ignored and the result is unchanged.

Source files
------------

// File: rtl/tensor_accumulate.sv
// Vector dot-product back end for the 2x2-bit tensor multiplier: per-lane
// saturating accumulation over len+1 beats, result held under valid/ready.

module tensor_acc_lane #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add,
  input  logic [3:0]       prod,
  output logic [ACC_W-1:0] acc,
  output logic             clamp
);
  logic [ACC_W-1:0] acc_d, acc_q;
  logic [ACC_W:0]   sum;

  // One extra bit catches the carry that would otherwise wrap the lane.
  assign sum   = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, prod};
  assign clamp = sum[ACC_W];
  assign acc   = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr)      acc_d = '0;
    else if (add) acc_d = clamp ? '1 : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
endmodule

module tensor_accumulate #(
  parameter int ACC_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       prod_high,
  input  logic [3:0]       prod_low,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_high,
  output logic [ACC_W-1:0] acc_low,
  output logic [ACC_W:0]   dot,
  output logic             sat,
  output logic             busy
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                              state_d, state_q;
  logic [LEN_W-1:0]                    len_d, len_q;
  logic [LEN_W:0]                      cnt_d, cnt_q;
  logic                                sat_d, sat_q;
  logic                                clr, accept;
  logic [NUM_LANES-1:0][3:0]           prod;
  logic [NUM_LANES-1:0][ACC_W-1:0]     acc;
  logic [NUM_LANES-1:0]                clamp;

  assign prod   = {prod_high, prod_low};
  assign clr    = (state_q == IDLE) && start && !abort;
  assign accept = (state_q == ACCUM) && in_valid && !abort;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tensor_acc_lane #(.ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .add   (accept),
      .prod  (prod[i]),
      .acc   (acc[i]),
      .clamp (clamp[i])
    );
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (start) begin
          len_d   = len;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
        ACCUM: if (in_valid) begin
          // Counter is one bit wider than len so the all-ones length compares cleanly.
          cnt_d = cnt_q + 1'b1;
          sat_d = sat_q | (|clamp);
          if (cnt_q == {1'b0, len_q}) state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign acc_high  = acc[1];
  assign acc_low   = acc[0];
  assign dot       = {1'b0, acc[1]} + {1'b0, acc[0]};
  assign sat       = sat_q;
endmodule

// File: tb/tb_tensor_accumulate.sv
// Directed bench for tensor_accumulate: default-width unit plus a 6-bit unit
// sharing the same stimulus to exercise lane saturation.

module tb_tensor_accumulate;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] len = '0, prod_high = '0, prod_low = '0;

  logic       in_ready, out_valid, sat, busy;
  logic [7:0] acc_high, acc_low;
  logic [8:0] dot;
  logic       in_ready6, out_valid6, sat6, busy6;
  logic [5:0] acc_high6, acc_low6;
  logic [6:0] dot6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tensor_accumulate #(.ACC_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .prod_high(prod_high),
    .prod_low(prod_low), .out_valid(out_valid), .out_ready(out_ready),
    .acc_high(acc_high), .acc_low(acc_low), .dot(dot), .sat(sat), .busy(busy)
  );

  tensor_accumulate #(.ACC_W(6), .LEN_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready6), .prod_high(prod_high),
    .prod_low(prod_low), .out_valid(out_valid6), .out_ready(out_ready),
    .acc_high(acc_high6), .acc_low(acc_low6), .dot(dot6), .sat(sat6), .busy(busy6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] h, input logic [3:0] l);
    in_valid = 1'b1; prod_high = h; prod_low = l;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic go(input logic [3:0] n);
    start = 1'b1; len = n;
    tick();
    start = 1'b0;
  endtask

  task automatic res(input string tag, input int h, input int l, input int d, input int s);
    chk({tag, " acc_high"}, acc_high, h);
    chk({tag, " acc_low"},  acc_low,  l);
    chk({tag, " dot"},      dot,      d);
    chk({tag, " sat"},      sat,      s);
  endtask

  initial begin
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset busy", busy, 0);
    res("reset", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic vector of four back-to-back beats.
    go(4'd3);
    chk("basic in_ready", in_ready, 1);
    chk("basic busy", busy, 1);
    beat(4'd9, 4'd4);
    in_valid = 1'b1;
    prod_high = 4'd1; prod_low = 4'd2; tick();
    prod_high = 4'd0; prod_low = 4'd3; tick();
    chk("basic not early", out_valid, 0);
    prod_high = 4'd6; prod_low = 4'd6; tick();
    in_valid = 1'b0;
    chk("basic out_valid", out_valid, 1);
    chk("basic in_ready done", in_ready, 0);
    res("basic", 16, 15, 31, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("basic idle", busy, 0);
    chk("basic out_valid drop", out_valid, 0);
    res("basic hold", 16, 15, 31, 0);

    // Stalls and backpressure.
    go(4'd1);
    beat(4'd3, 4'd3);
    tick(); tick();
    chk("stall waiting", out_valid, 0);
    beat(4'd2, 4'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", out_valid, 1);
      res("bp", 5, 4, 9, 0);
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("bp idle", busy, 0);

    // len = 0 single element, then full-length vector.
    go(4'd0);
    beat(4'd9, 4'd9);
    chk("len0 out_valid", out_valid, 1);
    res("len0", 9, 9, 18, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    go(4'd15);
    for (int i = 0; i < 15; i++) beat(4'd9, 4'd9);
    chk("len15 not early", out_valid, 0);
    beat(4'd9, 4'd9);
    chk("len15 out_valid", out_valid, 1);
    res("len15", 144, 144, 288, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Saturation on the 6-bit unit.
    go(4'd15);
    for (int i = 0; i < 16; i++) beat(4'd9, 4'd1);
    chk("sat6 out_valid", out_valid6, 1);
    chk("sat6 acc_high", acc_high6, 63);
    chk("sat6 acc_low", acc_low6, 16);
    chk("sat6 dot", dot6, 79);
    chk("sat6 sat", sat6, 1);
    res("nosat8", 144, 16, 160, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("sat6 sticky idle", sat6, 1);

    // Next start clears sat; then abort after two beats.
    go(4'd3);
    chk("sat6 cleared", sat6, 0);
    chk("start clears acc", acc_high6, 0);
    beat(4'd1, 4'd1);
    beat(4'd2, 4'd3);
    abort = 1'b1; in_valid = 1'b1; prod_high = 4'd5; prod_low = 4'd5;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort idle", busy, 0);
    chk("abort in_ready", in_ready, 0);
    res("abort partial", 3, 4, 7, 0);
    tick(); tick();
    chk("abort no out_valid", out_valid, 0);

    // start together with abort in IDLE stays idle.
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start+abort idle", busy, 0);
    res("start+abort hold", 3, 4, 7, 0);

    // start during DONE is ignored.
    go(4'd0);
    beat(4'd1, 4'd2);
    start = 1'b1; len = 4'd5; tick(); start = 1'b0;
    chk("done start ignored", out_valid, 1);
    res("done start", 1, 2, 3, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("done released", busy, 0);

    // Asynchronous reset mid-ACCUM.
    go(4'd7);
    beat(4'd2, 4'd2); beat(4'd2, 4'd2); beat(4'd2, 4'd2);
    chk("pre-reset acc", acc_high, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async busy", busy, 0);
    chk("async in_ready", in_ready, 0);
    chk("async out_valid", out_valid, 0);
    res("async", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-reset idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
